bcd_display_scan: RTL

Time-multiplexed 4-digit seven-segment display driver that consumes the four BCD digits (thousands, hundreds, tens, ones) produced by the binary-to-BCD converter. It captures a digit set on a load strobe and holds it in a shadow register. The shadow is committed to the visible register only at a frame boundary, so a digit set is never torn across a scan. The block cycles through the digits at a programmable refresh rate and drives registered segment and anode outputs.

---
 rtl/bcd_display_scan.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed seven-segment driver for BCD digits.
// Loads land in a shadow register and become visible only at a frame boundary.
module bcd_display_scan #(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter bit          COMMON_ANODE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] thousands,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] ones,
    input  logic       blank_lz,
    input  logic       en,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_start
);

    localparam int unsigned   PW       = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] PCNT_ONE = PW'(1'b1);
    localparam logic [6:0]    SEG_OFF  = {7{COMMON_ANODE}};
    localparam logic [3:0]    AN_OFF   = {4{COMMON_ANODE}};

    // Logical active-high segment pattern {g,f,e,d,c,b,a}; non-BCD shows a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = 7'h40;
        endcase
        return pattern;
    endfunction

    logic [PW-1:0] r_pcnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_shadow;
    logic [15:0]   r_visible;
    logic          r_pending;
    logic          r_frame_start;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;

    logic          w_tc;
    logic          w_boundary;
    logic [15:0]   w_load_digits;
    logic [PW-1:0] w_pcnt_nxt;
    logic [1:0]    w_idx_nxt;
    logic [15:0]   w_shadow_nxt;
    logic [15:0]   w_visible_nxt;
    logic          w_pending_nxt;
    logic [3:0]    w_digit;
    logic          w_lead_zero;
    logic [6:0]    w_seg_log;
    logic [3:0]    w_an_log;
    logic          w_z3;
    logic          w_z2;
    logic          w_z1;

    assign w_tc          = (r_pcnt == PCNT_MAX);
    assign w_boundary    = w_tc && (r_idx == 2'd0);
    assign w_load_digits = {thousands, hundreds, tens, ones};

    assign w_z3 = (r_visible[15:12] == 4'd0);
    assign w_z2 = w_z3 && (r_visible[11:8] == 4'd0);
    assign w_z1 = w_z2 && (r_visible[7:4] == 4'd0);

    // Prescaler and scan index; index wraps 0 -> 3 on its own two-bit underflow.
    always_comb begin
        w_pcnt_nxt = r_pcnt;
        w_idx_nxt  = r_idx;
        if (w_tc) begin
            w_pcnt_nxt = {PW{1'b0}};
            w_idx_nxt  = r_idx - 2'd1;
        end else begin
            w_pcnt_nxt = r_pcnt + PCNT_ONE;
            w_idx_nxt  = r_idx;
        end
    end

    // Shadow/visible commit: a load on the boundary bypasses the shadow.
    always_comb begin
        w_shadow_nxt  = r_shadow;
        w_visible_nxt = r_visible;
        w_pending_nxt = r_pending;
        if (load) begin
            w_shadow_nxt = w_load_digits;
        end else begin
            w_shadow_nxt = r_shadow;
        end
        if (w_boundary && load) begin
            w_visible_nxt = w_load_digits;
            w_pending_nxt = 1'b0;
        end else if (w_boundary && r_pending) begin
            w_visible_nxt = r_shadow;
            w_pending_nxt = 1'b0;
        end else if (load) begin
            w_pending_nxt = 1'b1;
        end else begin
            w_pending_nxt = r_pending;
        end
    end

    // Select the digit under scan and whether it is a leading zero.
    always_comb begin
        w_digit     = r_visible[3:0];
        w_lead_zero = 1'b0;
        case (r_idx)
            2'd3: begin
                w_digit     = r_visible[15:12];
                w_lead_zero = w_z3;
            end
            2'd2: begin
                w_digit     = r_visible[11:8];
                w_lead_zero = w_z2;
            end
            2'd1: begin
                w_digit     = r_visible[7:4];
                w_lead_zero = w_z1;
            end
            default: begin
                w_digit     = r_visible[3:0];
                w_lead_zero = 1'b0;
            end
        endcase
    end

    // Logical segment/anode values; a blanked digit keeps its anode lit.
    always_comb begin
        w_seg_log = 7'h00;
        w_an_log  = 4'h0;
        if (blank_lz && w_lead_zero) begin
            w_seg_log = 7'h00;
        end else begin
            w_seg_log = seg_decode(w_digit);
        end
        if (en) begin
            w_an_log = 4'b0001 << r_idx;
        end else begin
            w_an_log = 4'h0;
        end
    end

    // Scan, digit storage and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt        <= {PW{1'b0}};
            r_idx         <= 2'd3;
            r_shadow      <= 16'h0000;
            r_visible     <= 16'h0000;
            r_pending     <= 1'b0;
            r_frame_start <= 1'b0;
            r_seg         <= SEG_OFF;
            r_an          <= AN_OFF;
        end else begin
            r_pcnt        <= w_pcnt_nxt;
            r_idx         <= w_idx_nxt;
            r_shadow      <= w_shadow_nxt;
            r_visible     <= w_visible_nxt;
            r_pending     <= w_pending_nxt;
            r_frame_start <= w_boundary;
            r_seg         <= w_seg_log ^ SEG_OFF;
            r_an          <= w_an_log ^ AN_OFF;
        end
    end

    assign seg         = r_seg;
    assign an          = r_an;
    assign frame_start = r_frame_start;

endmodule
